// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags, refilled by commit and revert.
// Optional double-free detection is enabled by defining PHYS_REG_FREE_LIST_DUP_CHECK_EN.
module phys_reg_free_list #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
    parameter int PW            = $clog2(NUM_PHYS_REGS),
    parameter int DW            = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          nRST,
    output logic          DUT_error,
    output logic          free_valid,
    output logic [PW-1:0] free_tag,
    input  logic          dequeue,
    input  logic          commit_free_valid,
    input  logic [PW-1:0] commit_free_tag,
    input  logic          revert_free_valid,
    input  logic [PW-1:0] revert_free_tag,
    output logic [DW:0]   free_count
);

    localparam logic [DW:0] DEPTH_C = (DW+1)'(DEPTH);

    logic [PW-1:0] r_array [DEPTH];
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [DW:0]   r_count;
    logic          r_error;

    logic          w_deq_acc;
    logic [DW:0]   w_post_cnt;
    logic [DW:0]   w_space;
    logic          w_commit_dup;
    logic          w_revert_dup;
    logic          w_commit_ok;
    logic          w_revert_ok;
    logic          w_commit_acc;
    logic          w_revert_acc;
    logic [DW-1:0] w_revert_slot;
    logic          w_next_error;

    assign free_valid = (r_count != '0);
    assign free_tag   = r_array[r_head];
    assign free_count = r_count;
    assign DUT_error  = r_error;

`ifdef PHYS_REG_FREE_LIST_DUP_CHECK_EN
    logic [NUM_PHYS_REGS-1:0] r_bitmap;

    // A revert carrying the same tag as a commit in the same cycle is a double free.
    assign w_commit_dup = r_bitmap[commit_free_tag];
    assign w_revert_dup = r_bitmap[revert_free_tag] |
                          (commit_free_valid & (revert_free_tag == commit_free_tag));

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_bitmap <= {{DEPTH{1'b1}}, {NUM_ARCH_REGS{1'b0}}};
        end else begin
            if (w_deq_acc)    r_bitmap[free_tag]        <= 1'b0;
            if (w_commit_acc) r_bitmap[commit_free_tag] <= 1'b1;
            if (w_revert_acc) r_bitmap[revert_free_tag] <= 1'b1;
        end
    end
`else
    assign w_commit_dup = 1'b0;
    assign w_revert_dup = 1'b0;
`endif

    // Capacity is judged after this cycle's dequeue; revert loses to commit on overflow.
    assign w_deq_acc     = dequeue & free_valid;
    assign w_post_cnt    = r_count - (DW+1)'(w_deq_acc);
    assign w_space       = DEPTH_C - w_post_cnt;
    assign w_commit_ok   = commit_free_valid & (commit_free_tag != '0) & ~w_commit_dup;
    assign w_revert_ok   = revert_free_valid & (revert_free_tag != '0) & ~w_revert_dup;
    assign w_commit_acc  = w_commit_ok & (w_space != '0);
    assign w_revert_acc  = w_revert_ok & (w_space > (DW+1)'(w_commit_acc));
    assign w_revert_slot = r_tail + DW'(w_commit_acc);
    assign w_next_error  = (dequeue & ~free_valid) |
                           (commit_free_valid & ~w_commit_acc) |
                           (revert_free_valid & ~w_revert_acc);

    always_ff @(posedge CLK) begin
        if (nRST) begin
            // NOTE: the tag array is reset on purpose: its contents define the initial free tags.
            for (int i = 0; i < DEPTH; i++) begin
                r_array[i] <= PW'(NUM_ARCH_REGS + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= DEPTH_C;
            r_error <= 1'b0;
        end else begin
            if (w_commit_acc) r_array[r_tail]        <= commit_free_tag;
            if (w_revert_acc) r_array[w_revert_slot] <= revert_free_tag;
            r_head  <= r_head + DW'(w_deq_acc);
            r_tail  <= r_tail + DW'(w_commit_acc) + DW'(w_revert_acc);
            r_count <= w_post_cnt + (DW+1)'(w_commit_acc) + (DW+1)'(w_revert_acc);
            r_error <= w_next_error;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: directed steps push expected state,
// a negedge monitor pops and compares one cycle after each step's clock edge.
module tb_phys_reg_free_list;

    localparam int PW = 6;
    localparam int DW = 5;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          DUT_error;
    logic          free_valid;
    logic [PW-1:0] free_tag;
    logic          dequeue;
    logic          commit_free_valid;
    logic [PW-1:0] commit_free_tag;
    logic          revert_free_valid;
    logic [PW-1:0] revert_free_tag;
    logic [DW:0]   free_count;

    phys_reg_free_list dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .DUT_error         (DUT_error),
        .free_valid        (free_valid),
        .free_tag          (free_tag),
        .dequeue           (dequeue),
        .commit_free_valid (commit_free_valid),
        .commit_free_tag   (commit_free_tag),
        .revert_free_valid (revert_free_valid),
        .revert_free_tag   (revert_free_tag),
        .free_count        (free_count)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            step;
        logic          v;
        logic [PW-1:0] tag;
        logic [DW:0]   cnt;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   step_no  = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus; the expected state is what the DUT shows after the next edge.
    task automatic step(input logic rst, input logic d,
                        input logic c_v, input int c_t,
                        input logic r_v, input int r_t,
                        input logic ev, input int etag, input int ecnt, input logic eerr);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST              = rst;
        dequeue           = d;
        commit_free_valid = c_v;
        commit_free_tag   = PW'(c_t);
        revert_free_valid = r_v;
        revert_free_tag   = PW'(r_t);
        e.due  = cyc + 1;
        e.step = step_no;
        e.v    = ev;
        e.tag  = PW'(etag);
        e.cnt  = (DW+1)'(ecnt);
        e.err  = eerr;
        sb.push_back(e);
        step_no++;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check($sformatf("step%0d.due", e.step), 32'(cyc), 32'(e.due));
            check($sformatf("step%0d.free_valid", e.step), 32'(free_valid), 32'(e.v));
            check($sformatf("step%0d.free_count", e.step), 32'(free_count), 32'(e.cnt));
            check($sformatf("step%0d.DUT_error", e.step), 32'(DUT_error), 32'(e.err));
            if (e.v) check($sformatf("step%0d.free_tag", e.step), 32'(free_tag), 32'(e.tag));
        end
    end

    initial begin
        nRST              = 1'b0;
        dequeue           = 1'b0;
        commit_free_valid = 1'b0;
        commit_free_tag   = '0;
        revert_free_valid = 1'b0;
        revert_free_tag   = '0;

        // Reset with in-flight traffic that must be discarded, then idle.
        step(1, 1, 1, 7, 1, 8,  1, 32, 32, 0);
        step(0, 0, 0, 0, 0, 0,  1, 32, 32, 0);

        // Drain all 32 initial tags: head steps 32..63, then empty.
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 0, 0, 0, 0,  (i < 31), 33 + i, 31 - i, 0);
        end
        // Dequeue on empty: ignored, error pulse, then pulse clears.
        step(0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Dual enqueue from empty: commit lands first.
        step(0, 0, 1, 5, 1, 9,  1, 5, 2, 0);
        step(0, 1, 0, 0, 0, 0,  1, 9, 1, 0);
        step(0, 1, 0, 0, 0, 0,  0, 0, 0, 0);

        // Full: dequeue plus enqueue of 40 is legal; 40 emerges after wrap.
        step(1, 0, 0, 0, 0, 0,  1, 32, 32, 0);
        step(0, 1, 1, 40, 0, 0, 1, 33, 32, 0);
        for (int j = 0; j < 31; j++) begin
            step(0, 1, 0, 0, 0, 0,  1, (j < 30) ? 34 + j : 40, 31 - j, 0);
        end
        step(0, 1, 0, 0, 0, 0,  0, 0, 0, 0);

        // Overflow and tag-0 drops.
        step(1, 0, 0, 0, 0, 0,  1, 32, 32, 0);
        step(0, 0, 1, 7, 0, 0,  1, 32, 32, 1);
        step(0, 1, 0, 0, 0, 0,  1, 33, 31, 0);
        step(0, 0, 1, 0, 0, 0,  1, 33, 31, 1);
        step(0, 0, 0, 0, 1, 0,  1, 33, 31, 1);
        step(0, 0, 0, 0, 0, 0,  1, 33, 31, 0);
        step(0, 0, 1, 11, 1, 12, 1, 33, 32, 1);
        step(0, 1, 1, 13, 1, 14, 1, 34, 32, 1);

        // Double-free cases; expectations differ with the duplicate check.
        step(1, 0, 0, 0, 0, 0,  1, 32, 32, 0);
        step(0, 0, 1, 33, 0, 0, 1, 32, 32, 1);
        step(0, 1, 0, 0, 0, 0,  1, 33, 31, 0);
`ifdef PHYS_REG_FREE_LIST_DUP_CHECK_EN
        step(0, 0, 0, 0, 1, 40, 1, 33, 31, 1);
`else
        step(0, 0, 0, 0, 1, 40, 1, 33, 32, 0);
`endif
        step(0, 0, 1, 32, 1, 32, 1, 33, 32, 1);
        step(0, 0, 0, 0, 0, 0,  1, 33, 32, 0);

        repeat (3) @(posedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Circular FIFO of free physical register tags; sits directly upstream of the physical register map table.
- Supplies rename_dest_phys_reg_tag to the map table when dispatch renames a destination.
- Refilled by two sources: commit (freed old dest tag) and ROB revert (freed speculated dest tag).
- Gives dispatch a valid/ready-style indication of tag availability.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; tags 0..NUM_ARCH_REGS-1 are mapped at reset and never start in the list.
- NUM_PHYS_REGS, 64, physical registers; tag width PW = log2(NUM_PHYS_REGS) = 6 (phys_reg_tag_t).
- DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS (32), FIFO capacity; must be a power of two. Pointer width DW = log2(DEPTH).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  reset, synchronous, active-high: asserted = 1, sampled on posedge CLK.
- DUT_error  out  1  registered error flag.
- free_valid  out  1  list non-empty; free_tag is meaningful.
- free_tag  out  PW  head tag, offered to rename.
- dequeue  in  1  rename consumes free_tag this cycle.
- commit_free_valid  in  1  commit returns a tag.
- commit_free_tag  in  PW  tag returned by commit.
- revert_free_valid  in  1  revert returns a speculated tag.
- revert_free_tag  in  PW  tag returned by revert.
- free_count  out  DW+1  number of entries in the list (0..DEPTH).

Behaviour:
- State: array[DEPTH] of PW bits, head pointer (DW bits), tail pointer (DW bits), count (DW+1 bits), DUT_error.
- Reset (nRST=1 at posedge):
  - array[i] = NUM_ARCH_REGS+i; head = 0; tail = 0; count = DEPTH.
  - Therefore free_valid = 1, free_tag = 32, free_count = 32, DUT_error = 0 in the cycle after reset.
  - Reset mid-operation discards all in-flight enqueue/dequeue in that cycle.
- Outputs (combinational from state):
  - free_valid = (count != 0).
  - free_tag = array[head].
  - free_count = count.
- Dequeue:
  - If dequeue & free_valid: head <= head+1 (mod DEPTH).
  - If dequeue & ~free_valid: ignored (no pointer/count change); next DUT_error = 1.
- Enqueue ordering (same cycle, both valid):
  - commit tag written at tail, revert tag at tail+1; tail <= tail+2.
  - Exactly one valid: that tag written at tail; tail <= tail+1.
  - All pointer arithmetic wraps mod DEPTH.
- Count update: count <= count + commit_free_valid + revert_free_valid - (dequeue & free_valid).
- Latency and bypass:
  - An enqueued tag is visible at free_tag no earlier than the next cycle.
  - No same-cycle enqueue-to-dequeue bypass; when empty, free_valid stays 0 during an enqueue cycle.
- Simultaneous dequeue and enqueue at full or non-empty: both proceed. Capacity is checked on the post-dequeue count, so full + 1 enqueue + 1 dequeue is legal.
- Overflow: if the resulting count would exceed DEPTH, the overflowing enqueue(s) are dropped, in revert-first order, and next DUT_error = 1.
- Tag 0: an enqueue of tag 0 is never written and raises next DUT_error = 1. Arch reg 0 is permanently mapped to phys reg 0.
- DUT_error: registered; next_DUT_error defaults to 0 each cycle and is set by any error condition listed. It is a one-cycle pulse per offending cycle.

Optional Feature:
- Macro: PHYS_REG_FREE_LIST_DUP_CHECK_EN.
- With the macro defined:
  - Maintain free_bitmap[NUM_PHYS_REGS]; reset value is bits NUM_ARCH_REGS..NUM_PHYS_REGS-1 set, all others clear.
  - Dequeue clears the bit of free_tag. An accepted enqueue sets its tag's bit.
  - Enqueue of a tag whose bit is already set (double free) is dropped and sets next DUT_error = 1.
  - Commit and revert both carrying the same tag in one cycle: commit is accepted, revert is dropped, error raised.
- Without the macro: no bitmap, duplicates are enqueued silently, and the logic has no free_bitmap storage.

Test Plan:
- Reset, then idle -> free_valid=1, free_tag=32, free_count=32, DUT_error=0.
- 32 consecutive dequeue cycles -> free_tag steps 32..63; then free_valid=0, free_count=0. A 33rd dequeue -> no change, DUT_error=1 the next cycle.
- From empty: commit_free_tag=5 and revert_free_tag=9 in the same cycle -> next cycle free_count=2, free_tag=5; after one dequeue free_tag=9.
- At full (32): dequeue plus commit enqueue of tag 40 in the same cycle -> free_count stays 32, no error; tag 40 emerges after 31 further dequeues (wrap-around check).
- At full: commit enqueue of tag 7 with no dequeue -> dropped, free_count=32, DUT_error=1. Separately, enqueue of tag 0 -> dropped, DUT_error=1.
- With PHYS_REG_FREE_LIST_DUP_CHECK_EN: after reset, commit enqueue of tag 33 (still free) -> dropped, DUT_error=1, free_count unchanged at 32.
